// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core (MEM stage) and a DMA/debug loader share one
// single-port dmem. Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise the core always wins ties.
module dmem_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic        c_stall,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [9:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        grant, pick_d;
  logic        sel_we, sel_mis;
  logic [31:0] sel_addr, sel_wdata;
  logic        owner_d, owner_we, owner_mis;
  logic [31:0] rdata_q, c_hold, d_hold, resp_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{c_addr[31:12], d_addr[31:12]};

`ifdef DMEM_ARB_RR_EN
  logic favour_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     favour_d <= 1'b0;
    else if (grant) favour_d <= ~pick_d;
  end

  assign pick_d = d_req & (~c_req | favour_d);
`else
  assign pick_d = d_req & ~c_req;
`endif

  // The grant path is purely combinational, so it is gated with rst_n to go quiet during reset.
  assign grant     = rst_n & (state == IDLE) & (c_req | d_req);
  assign sel_we    = pick_d ? d_we    : c_we;
  assign sel_addr  = pick_d ? d_addr  : c_addr;
  assign sel_wdata = pick_d ? d_wdata : c_wdata;
  assign sel_mis   = |sel_addr[1:0];

  // With no wait states the dmem output is live during RESP; otherwise it was captured at N+1.
  assign resp_data = owner_mis ? 32'h0 : ((WAIT_CYCLES == 0) ? m_rdata : rdata_q);

  always_comb begin
    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    err       = 1'b0;
    c_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          c_gnt   = ~pick_d;
          d_gnt   = pick_d;
          m_en    = ~sel_mis;
          m_we    = sel_we & ~sel_mis;
          m_addr  = sel_addr[11:2];
          m_wdata = sel_wdata;
          err     = sel_mis;
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 3'(WAIT_CYCLES);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt <= 3'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RESP: begin
        c_rvalid  = ~owner_d & ~owner_we;
        d_rvalid  = owner_d & ~owner_we;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign c_stall = rst_n & ((c_req & ~c_gnt) |
                   ((state == WAIT) & ~owner_d & ~owner_we));
  assign c_rdata = c_rvalid ? resp_data : c_hold;
  assign d_rdata = d_rvalid ? resp_data : d_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      owner_d   <= 1'b0;
      owner_we  <= 1'b0;
      owner_mis <= 1'b0;
      rdata_q   <= '0;
      c_hold    <= '0;
      d_hold    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        owner_d   <= pick_d;
        owner_we  <= sel_we;
        owner_mis <= sel_mis;
      end
      if (state == WAIT && cnt == 3'(WAIT_CYCLES)) rdata_q <= m_rdata;
      if (c_rvalid) c_hold <= resp_data;
      if (d_rvalid) d_hold <= resp_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (0 and 2 wait states), each with its own dmem,
// driven by directed and random transactions and checked against a word-array memory model.
module tb_dmem_arbiter;

  localparam int N = 2;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]        c_req, c_we, d_req, d_we;
  logic [N-1:0][31:0]  c_addr, c_wdata, d_addr, d_wdata;
  logic [N-1:0]        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
  logic [N-1:0][31:0]  c_rdata, d_rdata, m_wdata;
  logic [N-1:0]        m_en, m_we, err;
  logic [N-1:0][9:0]   m_addr;

  logic [31:0] init_mem [1024];
  logic [31:0] ref_mem  [N][1024];
  logic [31:0] last_c [N];
  logic [31:0] last_d [N];
  bit          last_was_d [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_inst
    logic [31:0] mem [1024];
    logic [31:0] rd;
    bit          loaded = 1'b0;

    dmem_arbiter #(.WAIT_CYCLES(2 * g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .c_req    (c_req[g]),
      .c_we     (c_we[g]),
      .c_addr   (c_addr[g]),
      .c_wdata  (c_wdata[g]),
      .c_gnt    (c_gnt[g]),
      .c_rvalid (c_rvalid[g]),
      .c_stall  (c_stall[g]),
      .c_rdata  (c_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .m_en     (m_en[g]),
      .m_we     (m_we[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_rdata  (rd),
      .err      (err[g])
    );

    // Synchronous single-port dmem; contents preloaded on the first clock edge.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 1024; i++) mem[i] <= init_mem[i];
        loaded <= 1'b1;
      end else if (m_en[g]) begin
        if (m_we[g]) mem[m_addr[g]] <= m_wdata[g];
        else         rd <= mem[m_addr[g]];
      end
    end
  end

  task automatic check(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL inst%0d %s: observed %h expected %h", k, tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input int k);
    check(k, "rst c_gnt",    c_gnt[k],    0);
    check(k, "rst d_gnt",    d_gnt[k],    0);
    check(k, "rst c_rvalid", c_rvalid[k], 0);
    check(k, "rst d_rvalid", d_rvalid[k], 0);
    check(k, "rst m_en",     m_en[k],     0);
    check(k, "rst m_we",     m_we[k],     0);
    check(k, "rst err",      err[k],      0);
    check(k, "rst m_addr",   m_addr[k],   0);
    check(k, "rst m_wdata",  m_wdata[k],  0);
    check(k, "rst c_rdata",  c_rdata[k],  0);
    check(k, "rst d_rdata",  d_rdata[k],  0);
    check(k, "rst c_stall",  c_stall[k],  0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      last_c[k]     = '0;
      last_d[k]     = '0;
      last_was_d[k] = 1'b1;
    end
  endtask

  // One transaction starting from IDLE; inputs change #1 after posedge, outputs are sampled at negedge.
  task automatic txn(input int k, input bit cr, input bit dr, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd);
    int          w, idx;
    bit          win_d, mis, resp;
    logic [31:0] exp_rd;
    w = 2 * k;
    if (cr && dr) win_d = RR ? !last_was_d[k] : 1'b0;
    else          win_d = dr;
    mis = (addr % 4) != 0;
    idx = (addr / 4) % 1024;
    c_req[k] = cr; c_we[k] = we; c_addr[k] = addr; c_wdata[k] = wd;
    d_req[k] = dr; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;

    @(negedge clk);
    check(k, "c_gnt",   c_gnt[k],   !win_d);
    check(k, "d_gnt",   d_gnt[k],   win_d);
    check(k, "m_en",    m_en[k],    !mis);
    check(k, "m_we",    m_we[k],    we && !mis);
    check(k, "m_addr",  m_addr[k],  idx);
    check(k, "m_wdata", m_wdata[k], wd);
    check(k, "err",     err[k],     mis);
    check(k, "c_stall grant", c_stall[k], cr && win_d);
    check(k, "c_rdata hold",  c_rdata[k], last_c[k]);
    check(k, "d_rdata hold",  d_rdata[k], last_d[k]);
    exp_rd = mis ? 32'h0 : ref_mem[k][idx];
    if (we && !mis) ref_mem[k][idx] = wd;
    last_was_d[k] = win_d;

    @(posedge clk); #1;
    if (win_d) d_req[k] = 1'b0;
    else       c_req[k] = 1'b0;

    for (int j = 1; j <= w + 1; j++) begin
      @(negedge clk);
      resp = (j == w + 1);
      check(k, "busy gnt",  c_gnt[k] | d_gnt[k], 0);
      check(k, "busy m_en", m_en[k], 0);
      check(k, "busy err",  err[k],  0);
      check(k, "c_rvalid",  c_rvalid[k], resp && !win_d && !we);
      check(k, "d_rvalid",  d_rvalid[k], resp && win_d && !we);
      check(k, "c_stall busy", c_stall[k], c_req[k] || (!resp && !win_d && !we));
      if (resp && !we) begin
        if (win_d) begin
          check(k, "d_rdata", d_rdata[k], exp_rd);
          last_d[k] = exp_rd;
        end else begin
          check(k, "c_rdata", c_rdata[k], exp_rd);
          last_c[k] = exp_rd;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drop_all();
    c_req = '0;
    d_req = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) init_mem[i] = $urandom;
    init_mem[4] = 32'hDEADBEEF;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_mem[i];
    model_reset();

    // Requests pending while in reset must not leak through.
    c_we = '0; d_we = '0; c_wdata = '0; d_wdata = '0;
    c_req = '1; d_req = '1;
    c_addr = {32'h40, 32'h40};
    d_addr = {32'h44, 32'h44};
    #12;
    for (int k = 0; k < N; k++) check_quiet(k);
    @(posedge clk); #1;
    drop_all();
    rst_n = 1'b1;

    // Core read of dmem[4], zero wait states.
    txn(0, 1, 0, 0, 32'h10, 32'h0);
    @(negedge clk);
    check(0, "deadbeef held", c_rdata[0], 32'hDEADBEEF);
    @(posedge clk); #1;

    // Write then read with two wait states.
    txn(1, 1, 0, 1, 32'h20, 32'h12345678);
    txn(1, 1, 0, 0, 32'h20, 32'h0);
    @(negedge clk);
    check(1, "wr-rd held", c_rdata[1], 32'h12345678);
    @(posedge clk); #1;

    // Both requesters held together for four transactions.
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 4; t++) txn(k, 1, 1, 0, 32'h100 + 32'(4 * t), 32'h0);
      drop_all();
    end

    // Misaligned loader read and address wrap at the 4 KiB boundary.
    for (int k = 0; k < N; k++) begin
      txn(k, 0, 1, 0, 32'h7, 32'h0);
      txn(k, 1, 0, 1, 32'hFFC, $urandom);
      txn(k, 0, 1, 1, 32'h1000, $urandom);
      txn(k, 1, 0, 0, 32'hFFC, 32'h0);
      txn(k, 0, 1, 0, 32'h0, 32'h0);
    end

    // Random traffic.
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 60; t++) begin
        int          who;
        logic [31:0] a;
        who = $urandom_range(0, 2);
        a   = 32'($urandom_range(0, 32'h1FFF));
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        txn(k, who != 1, who != 0, 1'($urandom_range(0, 1)), a, $urandom);
        drop_all();
      end
    end

    // Reset while a core read on the wait-state instance is in WAIT.
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h40;
    @(negedge clk);
    check(1, "pre-reset gnt", c_gnt[1], 1);
    @(posedge clk); #1;
    c_req[1] = 1'b0;
    @(negedge clk);
    check(1, "wait stall", c_stall[1], 1);
    #1 rst_n = 1'b0;
    c_req[1] = 1'b1;
    #1;
    for (int k = 0; k < N; k++) check_quiet(k);
    model_reset();
    @(posedge clk); #1;
    c_req[1] = 1'b0;
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check(1, "no rvalid after reset", c_rvalid[1], 0);
    end
    @(posedge clk); #1;
    txn(1, 1, 1, 0, 32'h10, 32'h0);
    txn(0, 0, 1, 0, 32'h10, 32'h0);
    drop_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
